// File: rtl/exu_wb_arb_pkg.sv
// Shared types for the EXU writeback arbiter.
// Source ids, request bundle and a one-hot pick helper.
package exu_wb_arb_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_UNITS = 4;

    typedef enum logic [2:0] {
        SRC_ALU,
        SRC_LSU,
        SRC_DIV,
        SRC_MUL,
        SRC_MAC
    } wb_src_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Lowest set bit wins: index 0 (LSU) has the highest priority.
    function automatic logic [NUM_UNITS-1:0] first_one(
        input logic [NUM_UNITS-1:0] v
    );
        return v & (-v);
    endfunction

endpackage

// File: rtl/exu_wb_arb_if.sv
// Unit-to-arbiter result handshake.
// Producer holds valid/rd_addr/data stable until ready.
interface exu_wb_arb_if;
    import exu_wb_arb_pkg::*;

    logic            valid;
    logic            ready;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] data;

    modport master (output valid, rd_addr, data, input ready);
    modport slave  (input valid, rd_addr, data, output ready);

endinterface

// File: rtl/exu_wb_arb_hold_reg.sv
// One-entry result hold with ageing.
// Writes to x0 are accepted and silently dropped.
module wb_hold_reg
    import exu_wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_data,
    output logic            ready,
    input  logic            grant,
    output wb_req_t         req,
    output logic            starved
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age;
    logic             accept;

    assign ready   = ~req.valid | grant;
    assign accept  = in_valid & ready & (in_rd_addr != 5'd0);
    assign starved = req.valid & (age >= AGE_MAX);

    // Capture, release on grant, age while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req <= '0;
            age <= '0;
        end else if (accept) begin
            req.valid   <= 1'b1;
            req.rd_addr <= in_rd_addr;
            req.data    <= in_data;
            age         <= '0;
        end else if (grant) begin
            req.valid <= 1'b0;
            age       <= '0;
        end else if (req.valid && age < AGE_MAX) begin
            age <= age + AGE_W'(1);
        end
    end

    // Producer must not withdraw or change a pending result.
    a_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        in_valid && !ready |=>
            in_valid && $stable(in_rd_addr) && $stable(in_data)
    );

endmodule

// File: rtl/exu_wb_arb.sv
// EXU writeback arbiter: ALU/LSU/DIV/MUL/MAC onto one
// registered writeback port with ageing and ALU stall.
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_wb_valid,
    input  logic [4:0]        alu_wb_rd_addr,
    input  logic [XLEN-1:0]   alu_wb_data,
    exu_wb_arb_if.slave       lsu_wb,
    exu_wb_arb_if.slave       div_wb,
    exu_wb_arb_if.slave       mul_wb,
    exu_wb_arb_if.slave       mac_wb,
    output logic [XLEN-1:0]   exu_wb_data,
    output logic [4:0]        exu_wb_rd_addr,
    output logic              exu_wb_rd_wr_en,
    output logic              wb_stall,
    output logic [CNT_W-1:0]  wb_conflict_cnt
);

    wb_req_t              unit_req [NUM_UNITS];
    logic [NUM_UNITS-1:0] unit_vld;
    logic [NUM_UNITS-1:0] unit_starved;
    logic [NUM_UNITS-1:0] unit_grant;

    wb_req_t alu_hold;
    wb_req_t alu_in;
    wb_req_t sel;
    wb_src_e sel_src;
    logic    alu_in_valid;
    logic    alu_in_grant;
    logic    alu_hold_grant;
    logic    multi_cand;
    logic    rd_dup;
    logic    unused_alu_ready;
    logic    unused_alu_starved;

    assign alu_in_valid = alu_wb_valid & (alu_wb_rd_addr != 5'd0);
    assign alu_in       = '{alu_in_valid, alu_wb_rd_addr, alu_wb_data};

    wb_hold_reg #(.STARVE_LIMIT(STARVE_LIMIT)) u_lsu (
        .clk(clk), .rst_n(rst_n),
        .in_valid(lsu_wb.valid), .in_rd_addr(lsu_wb.rd_addr),
        .in_data(lsu_wb.data), .ready(lsu_wb.ready),
        .grant(unit_grant[0]), .req(unit_req[0]),
        .starved(unit_starved[0])
    );

    wb_hold_reg #(.STARVE_LIMIT(STARVE_LIMIT)) u_div (
        .clk(clk), .rst_n(rst_n),
        .in_valid(div_wb.valid), .in_rd_addr(div_wb.rd_addr),
        .in_data(div_wb.data), .ready(div_wb.ready),
        .grant(unit_grant[1]), .req(unit_req[1]),
        .starved(unit_starved[1])
    );

    wb_hold_reg #(.STARVE_LIMIT(STARVE_LIMIT)) u_mul (
        .clk(clk), .rst_n(rst_n),
        .in_valid(mul_wb.valid), .in_rd_addr(mul_wb.rd_addr),
        .in_data(mul_wb.data), .ready(mul_wb.ready),
        .grant(unit_grant[2]), .req(unit_req[2]),
        .starved(unit_starved[2])
    );

    wb_hold_reg #(.STARVE_LIMIT(STARVE_LIMIT)) u_mac (
        .clk(clk), .rst_n(rst_n),
        .in_valid(mac_wb.valid), .in_rd_addr(mac_wb.rd_addr),
        .in_data(mac_wb.data), .ready(mac_wb.ready),
        .grant(unit_grant[3]), .req(unit_req[3]),
        .starved(unit_starved[3])
    );

    // ALU hold: catches an ALU result that lost arbitration.
    // It always wins next cycle, so its ready is never low.
    wb_hold_reg #(.STARVE_LIMIT(STARVE_LIMIT)) u_alu (
        .clk(clk), .rst_n(rst_n),
        .in_valid(alu_wb_valid & ~alu_in_grant),
        .in_rd_addr(alu_wb_rd_addr),
        .in_data(alu_wb_data), .ready(unused_alu_ready),
        .grant(alu_hold_grant), .req(alu_hold),
        .starved(unused_alu_starved)
    );

    assign wb_stall = alu_hold.valid;

    // Collect hold-valid bits for priority picking.
    always_comb begin
        unit_vld = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_vld[i] = unit_req[i].valid;
        end
    end

    // One grant per cycle: alu_hold, starved unit, ALU, unit.
    always_comb begin
        alu_hold_grant = 1'b0;
        alu_in_grant   = 1'b0;
        unit_grant     = '0;
        if (alu_hold.valid) begin
            alu_hold_grant = 1'b1;
        end else if (|unit_starved) begin
            unit_grant = first_one(unit_starved);
        end else if (alu_in_valid) begin
            alu_in_grant = 1'b1;
        end else begin
            unit_grant = first_one(unit_vld);
        end
    end

    // Decode the one-hot grant to a source and mux its bundle.
    always_comb begin
        sel_src = SRC_ALU;
        unique case (1'b1)
            unit_grant[0]: sel_src = SRC_LSU;
            unit_grant[1]: sel_src = SRC_DIV;
            unit_grant[2]: sel_src = SRC_MUL;
            unit_grant[3]: sel_src = SRC_MAC;
            default:       sel_src = SRC_ALU;
        endcase
        unique case (sel_src)
            SRC_LSU: sel = unit_req[0];
            SRC_DIV: sel = unit_req[1];
            SRC_MUL: sel = unit_req[2];
            SRC_MAC: sel = unit_req[3];
            default: sel = alu_hold_grant ? alu_hold : alu_in;
        endcase
    end

    assign multi_cand =
        $countones({alu_hold.valid, alu_in_valid, unit_vld}) > 1;

    // Register the granted result; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exu_wb_data     <= '0;
            exu_wb_rd_addr  <= '0;
            exu_wb_rd_wr_en <= 1'b0;
        end else begin
            exu_wb_rd_wr_en <= sel.valid;
            if (sel.valid) begin
                exu_wb_data    <= sel.data;
                exu_wb_rd_addr <= sel.rd_addr;
            end
        end
    end

    // Saturating count of contended cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_conflict_cnt <= '0;
        end else if (multi_cand && wb_conflict_cnt != '1) begin
            wb_conflict_cnt <= wb_conflict_cnt + CNT_W'(1);
        end
    end

    // Detect two live candidates targeting the same register.
    always_comb begin
        wb_req_t cand [NUM_UNITS+2];
        rd_dup = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand[i] = unit_req[i];
        end
        cand[NUM_UNITS]   = alu_hold;
        cand[NUM_UNITS+1] = alu_in;
        for (int i = 0; i < NUM_UNITS + 2; i++) begin
            for (int j = i + 1; j < NUM_UNITS + 2; j++) begin
                if (cand[i].valid && cand[j].valid &&
                    cand[i].rd_addr == cand[j].rd_addr) begin
                    rd_dup = 1'b1;
                end
            end
        end
    end

    a_no_alu_in_stall: assert property (
        @(posedge clk) disable iff (!rst_n)
        wb_stall |-> !alu_wb_valid
    );

    a_no_rd_dup: assert property (
        @(posedge clk) disable iff (!rst_n)
        !rd_dup
    );

endmodule

// File: tb/tb_exu_wb_arb.sv
// Scoreboard bench for exu_wb_arb.
// Directed vectors; monitor checks every writeback pulse.
module tb_exu_wb_arb;
    import exu_wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_wb_valid = 1'b0;
    logic [4:0]  alu_wb_rd_addr = '0;
    logic [31:0] alu_wb_data = '0;
    logic [31:0] exu_wb_data;
    logic [4:0]  exu_wb_rd_addr;
    logic        exu_wb_rd_wr_en;
    logic        wb_stall;
    logic [15:0] wb_conflict_cnt;

    exu_wb_arb_if lsu_if ();
    exu_wb_arb_if div_if ();
    exu_wb_arb_if mul_if ();
    exu_wb_arb_if mac_if ();

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q [$];

    always #5 clk = ~clk;

    exu_wb_arb #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid),
        .alu_wb_rd_addr(alu_wb_rd_addr),
        .alu_wb_data(alu_wb_data),
        .lsu_wb(lsu_if),
        .div_wb(div_if),
        .mul_wb(mul_if),
        .mac_wb(mac_if),
        .exu_wb_data(exu_wb_data),
        .exu_wb_rd_addr(exu_wb_rd_addr),
        .exu_wb_rd_wr_en(exu_wb_rd_wr_en),
        .wb_stall(wb_stall),
        .wb_conflict_cnt(wb_conflict_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    // Monitor: every writeback pulse must match the queue head.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (exu_wb_rd_wr_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wb_unexpected: got rd %0d data %h expected none",
                             exu_wb_rd_addr, exu_wb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({exu_wb_rd_addr, exu_wb_data} !== e) begin
                        n_bad++;
                        $display("FAIL wb_data: got rd %0d data %h expected rd %0d data %h",
                                 exu_wb_rd_addr, exu_wb_data, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        lsu_if.valid = 0; lsu_if.rd_addr = 0; lsu_if.data = 0;
        div_if.valid = 0; div_if.rd_addr = 0; div_if.data = 0;
        mul_if.valid = 0; mul_if.rd_addr = 0; mul_if.data = 0;
        mac_if.valid = 0; mac_if.rd_addr = 0; mac_if.data = 0;

        // reset state
        @(negedge clk);
        chk("rst_wr_en", exu_wb_rd_wr_en, 0);
        chk("rst_data", exu_wb_data, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_cnt", wb_conflict_cnt, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {lsu_if.ready, div_if.ready, mul_if.ready, mac_if.ready}, 4'hf);

        // single ALU result, one-cycle latency
        cyc();
        alu_wb_valid = 1; alu_wb_rd_addr = 5; alu_wb_data = 32'hDEADBEEF;
        push(5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_wr_en_n", exu_wb_rd_wr_en, 0);
        cyc();
        alu_wb_valid = 0;
        @(negedge clk);
        chk("t1_wr_en_n1", exu_wb_rd_wr_en, 1);
        chk("t1_stall", wb_stall, 0);
        cyc();
        @(negedge clk);
        chk("t1_wr_en_n2", exu_wb_rd_wr_en, 0);

        // MUL and DIV together: DIV first
        cyc();
        mul_if.valid = 1; mul_if.rd_addr = 3; mul_if.data = 32'h11;
        div_if.valid = 1; div_if.rd_addr = 4; div_if.data = 32'h22;
        push(4, 32'h22);
        push(3, 32'h11);
        @(negedge clk);
        chk("t2_ready_in", {mul_if.ready, div_if.ready}, 2'b11);
        cyc();
        mul_if.valid = 0; div_if.valid = 0;
        @(negedge clk);
        chk("t2_mul_ready_lo", mul_if.ready, 0);
        chk("t2_div_ready", div_if.ready, 1);
        cyc();
        @(negedge clk);
        chk("t2_mul_ready_hi", mul_if.ready, 1);
        chk("t2_cnt", wb_conflict_cnt, 1);
        repeat (3) cyc();

        // MAC starvation against continuous ALU traffic
        cyc();
        mac_if.valid = 1; mac_if.rd_addr = 7; mac_if.data = 32'h77;
        for (int i = 0; i < 4; i++) push(5'(10 + i), 32'hA0 + i);
        push(7, 32'h77);
        push(14, 32'hA4);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cyc();
            mac_if.valid = 0;
            alu_wb_valid = 1;
            alu_wb_rd_addr = 5'(10 + i);
            alu_wb_data = 32'hA0 + i;
            @(negedge clk);
            if (i == 3) chk("t3_mac_wait", mac_if.ready, 0);
            if (i == 4) chk("t3_mac_grant", mac_if.ready, 1);
            chk("t3_stall_pre", wb_stall, 0);
        end
        cyc();
        alu_wb_valid = 0;
        @(negedge clk);
        chk("t3_stall", wb_stall, 1);
        cyc();
        @(negedge clk);
        chk("t3_stall_clr", wb_stall, 0);
        repeat (2) cyc();
        chk("t3_cnt", wb_conflict_cnt, 6);

        // LSU write to x0 is dropped
        cyc();
        lsu_if.valid = 1; lsu_if.rd_addr = 0; lsu_if.data = 32'h55;
        @(negedge clk);
        chk("t4_ready_in", lsu_if.ready, 1);
        cyc();
        lsu_if.valid = 0;
        @(negedge clk);
        chk("t4_ready", lsu_if.ready, 1);
        chk("t4_no_wr", exu_wb_rd_wr_en, 0);
        cyc();
        @(negedge clk);
        chk("t4_no_wr2", exu_wb_rd_wr_en, 0);
        chk("t4_cnt", wb_conflict_cnt, 6);

        // back-to-back LSU results
        for (int i = 0; i < 3; i++) begin
            cyc();
            lsu_if.valid = 1;
            lsu_if.rd_addr = 5'(1 + i);
            lsu_if.data = 32'h100 + i;
            push(5'(1 + i), 32'h100 + i);
            @(negedge clk);
            chk("t5_ready", lsu_if.ready, 1);
            if (i == 2) chk("t5_wr0", exu_wb_rd_wr_en, 1);
        end
        cyc();
        lsu_if.valid = 0;
        @(negedge clk);
        chk("t5_wr1", exu_wb_rd_wr_en, 1);
        cyc();
        @(negedge clk);
        chk("t5_wr2", exu_wb_rd_wr_en, 1);
        cyc();
        @(negedge clk);
        chk("t5_wr_end", exu_wb_rd_wr_en, 0);
        chk("t5_cnt", wb_conflict_cnt, 6);

        // reset with DIV and MAC holds full
        cyc();
        div_if.valid = 1; div_if.rd_addr = 8; div_if.data = 32'h88;
        mac_if.valid = 1; mac_if.rd_addr = 9; mac_if.data = 32'h99;
        cyc();
        div_if.valid = 0; mac_if.valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wr_en", exu_wb_rd_wr_en, 0);
        chk("t6_data", exu_wb_data, 0);
        chk("t6_rd", exu_wb_rd_addr, 0);
        chk("t6_stall", wb_stall, 0);
        chk("t6_cnt", wb_conflict_cnt, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready", {lsu_if.ready, div_if.ready, mul_if.ready, mac_if.ready}, 4'hf);
        repeat (4) cyc();
        @(negedge clk);
        chk("t6_no_wr", exu_wb_rd_wr_en, 0);
        chk("t6_cnt_after", wb_conflict_cnt, 0);
        chk("q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
